div_restoring: RTL and testbench
================================

# div_restoring

Sequential 32-bit signed integer divider serving the MIPS `div` instruction in the multicycle datapath. It takes operands straight from the A and B registers, iterates one quotient bit per clock, and hands remainder and quotient to the Hi and Lo registers through the SrcHiLo multiplexer. Control starts it with a one-cycle pulse, stalls on `busy`, and asserts HiLoWrite on `done`. A divide-by-zero indication feeds the exception path.

## Interface
- WIDTH, 32, operand/result width; the datapath uses only 32.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; forces the block to IDLE.
- start  in  1  one-cycle request; sampled only in IDLE.
- dividend  in  WIDTH  signed numerator, from register A.
- divisor  in  WIDTH  signed denominator, from register B.
- busy  out  1  high in RUN and FIX.
- done  out  1  one-cycle pulse: result valid, or divide-by-zero.
- div_zero  out  1  one-cycle pulse, coincident with `done`, when divisor==0.
- hi  out  WIDTH  remainder.
- lo  out  WIDTH  quotient.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: 32 iterations, 5-bit counter.
  - FIX: applies the sign correction.
  - DONE: one cycle.
- IDLE behaviour:
  - `start` && divisor!=0: latch |dividend|, |divisor|, sign_q = sign(dividend)^sign(divisor), sign_r = sign(dividend). Clear partial remainder and count. Go to RUN.
  - `start` && divisor==0: stay in IDLE. Pulse `done` and `div_zero` for one cycle. `hi`/`lo` unchanged.
- RUN, each cycle (restoring step):
  - rem = {rem[W-2:0], q[W-1]}, q <<= 1.
  - If rem >= divisor_abs: rem -= divisor_abs and q[0] = 1.
  - After count reaches 31 (32nd iteration), go to FIX.
- FIX:
  - lo = sign_q ? -q : q.
  - hi = sign_r ? -rem : rem.
  - Go to DONE.
- DONE: `done`=1, then return to IDLE.
- Semantics: quotient truncates toward zero; remainder takes the sign of the dividend; hi/lo satisfy dividend = lo*divisor + hi.
- Magnitudes are held in WIDTH bits (unsigned). |0x80000000| = 0x80000000 unsigned, so no extra bit is needed.
- Overflow case: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. It wraps, no flag.
- `start` outside IDLE is ignored. Operands are captured only at acceptance; later changes on `dividend`/`divisor` have no effect.
- `hi`/`lo` hold their last result until the next FIX.

## Timing
- Reset values (asserted at any time, including mid-RUN): state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0. The in-flight division is discarded and no `done` is produced.
- `start` accepted at edge N:
  - `busy` is high after edge N.
  - Last iteration at edge N+32; FIX→DONE at edge N+33.
  - After edge N+33: `done`=1, `busy`=0, hi/lo valid.
  - Back in IDLE after edge N+34, which is the earliest a new `start` can be accepted.
- Latency from `start` to `done`: 33 cycles. Back-to-back initiation interval: 34 cycles.
- Divide-by-zero: `done`/`div_zero` are high in the cycle after edge N, and `busy` never rises.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `div_pkg`:
  - state enum (IDLE, RUN, FIX, DONE).
  - DIV_WIDTH=32.
  - ITER_LAST=31.
- Optional combinational sub-module `div_step` covers one restoring iteration (rem, q, divisor → rem', q'). The top holds the FSM, counter, operand and result registers.

## Test plan
- 7 / 2 → after 33 cycles lo=3, hi=1, done pulse exactly one cycle, busy high for cycles 1–33.
- −7 (0xFFFFFFF9) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; 7 / −2 → lo=0xFFFFFFFD, hi=1.
- 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0; 0 / 5 → lo=0, hi=0.
- 100 / 0 after a previous result → done=div_zero=1 one cycle after start, busy stays 0, hi/lo retain the old values.
- Second `start` with different operands at cycle 10 of a 7/2 run → ignored; result still lo=3, hi=1.
- Reset asserted at cycle 15 of a run → outputs zero immediately. After release no `done` appears, and a new 9/4 gives lo=2, hi=1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Provides operand width, last iteration index, FSM state type and an
// absolute-value helper used when operands are accepted.
package div_pkg;

   localparam int unsigned DIV_WIDTH = 32;
   localparam int unsigned ITER_LAST = 31;
   localparam int unsigned CNT_W     = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } div_state_e;

   // Two's-complement magnitude; 0x80000000 maps to itself as an unsigned value.
   function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] x);
      return x[DIV_WIDTH-1] ? DIV_WIDTH'(-x) : x;
   endfunction

endpackage

// File: rtl/div_restoring_if.sv
// Request/result bundle between the multicycle controller and the divider.
//   start     : one-cycle request (controller -> divider)
//   dividend  : signed numerator   (controller -> divider)
//   divisor   : signed denominator (controller -> divider)
//   busy      : division in progress
//   done      : one-cycle completion pulse (also on divide-by-zero)
//   div_zero  : one-cycle pulse with done when divisor was zero
//   hi / lo   : remainder / quotient
interface div_restoring_if
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, dividend, divisor,
      input  busy, done, div_zero, hi, lo
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, div_zero, hi, lo
   );
endinterface

// File: rtl/div_step.sv
// One restoring iteration: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit in.
//   i_rem   : partial remainder (always below i_dvsr)
//   i_q     : dividend/quotient shift register
//   i_dvsr  : divisor magnitude
//   o_rem_c : next partial remainder
//   o_q_c   : next quotient shift register
module div_step
   import div_pkg::*;
(
   input  logic [DIV_WIDTH-1:0] i_rem,
   input  logic [DIV_WIDTH-1:0] i_q,
   input  logic [DIV_WIDTH-1:0] i_dvsr,
   output logic [DIV_WIDTH-1:0] o_rem_c,
   output logic [DIV_WIDTH-1:0] o_q_c
);
   localparam int unsigned W = DIV_WIDTH;

   logic [W:0] w_rem_sh;
   logic [W:0] w_diff;
   logic       w_fits;

   // The extra top bit keeps the shifted remainder exact; a borrow means no fit.
   assign w_rem_sh = {i_rem, i_q[W-1]};
   assign w_diff   = w_rem_sh - {1'b0, i_dvsr};
   assign w_fits   = ~w_diff[W];

   assign o_rem_c  = w_fits ? w_diff[W-1:0] : w_rem_sh[W-1:0];
   assign o_q_c    = {i_q[W-2:0], w_fits};
endmodule

// File: rtl/div_restoring.sv
// Sequential 32-bit signed divider, one quotient bit per clock.
// Quotient truncates toward zero; remainder takes the dividend's sign.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, aborts any division in flight
//   bus   : slave side of div_restoring_if (start/operands in, status/results out)
module div_restoring
   import div_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   div_restoring_if.slave bus
);
   localparam int unsigned W = DIV_WIDTH;

   div_state_e       r_state, w_state_nx;
   logic [W-1:0]     r_rem, w_rem_nx;
   logic [W-1:0]     r_q, w_q_nx;
   logic [W-1:0]     r_dvsr, w_dvsr_nx;
   logic             r_sign_q, w_sign_q_nx;
   logic             r_sign_r, w_sign_r_nx;
   logic [CNT_W-1:0] r_cnt, w_cnt_nx;
   logic [W-1:0]     r_hi, w_hi_nx;
   logic [W-1:0]     r_lo, w_lo_nx;
   logic             r_busy, w_busy_nx;
   logic             r_done, w_done_nx;
   logic             r_div_zero, w_div_zero_nx;
   logic [W-1:0]     w_step_rem;
   logic [W-1:0]     w_step_q;

   div_step u_step (
      .i_rem   (r_rem),
      .i_q     (r_q),
      .i_dvsr  (r_dvsr),
      .o_rem_c (w_step_rem),
      .o_q_c   (w_step_q)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nx;
   end

   // Next state, datapath updates and registered-output next values
   always_comb begin
      w_state_nx    = r_state;
      w_rem_nx      = r_rem;
      w_q_nx        = r_q;
      w_dvsr_nx     = r_dvsr;
      w_sign_q_nx   = r_sign_q;
      w_sign_r_nx   = r_sign_r;
      w_cnt_nx      = r_cnt;
      w_hi_nx       = r_hi;
      w_lo_nx       = r_lo;
      w_done_nx     = 1'b0;
      w_div_zero_nx = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               if (bus.divisor == '0) begin
                  // Report immediately without touching hi/lo.
                  w_done_nx     = 1'b1;
                  w_div_zero_nx = 1'b1;
               end else begin
                  w_state_nx  = ST_RUN;
                  w_rem_nx    = '0;
                  w_q_nx      = abs_val(bus.dividend);
                  w_dvsr_nx   = abs_val(bus.divisor);
                  w_sign_q_nx = bus.dividend[W-1] ^ bus.divisor[W-1];
                  w_sign_r_nx = bus.dividend[W-1];
                  w_cnt_nx    = '0;
               end
            end
         end
         ST_RUN: begin
            w_rem_nx = w_step_rem;
            w_q_nx   = w_step_q;
            w_cnt_nx = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(ITER_LAST)) w_state_nx = ST_FIX;
         end
         ST_FIX: begin
            w_lo_nx    = r_sign_q ? W'(-r_q)   : r_q;
            w_hi_nx    = r_sign_r ? W'(-r_rem) : r_rem;
            w_state_nx = ST_DONE;
         end
         ST_DONE: begin
            w_state_nx = ST_IDLE;
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase

      // Status flags follow the state being entered so they line up with it.
      w_busy_nx = (w_state_nx == ST_RUN) || (w_state_nx == ST_FIX);
      if (w_state_nx == ST_DONE) w_done_nx = 1'b1;
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rem      <= '0;
         r_q        <= '0;
         r_dvsr     <= '0;
         r_sign_q   <= 1'b0;
         r_sign_r   <= 1'b0;
         r_cnt      <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         r_rem      <= w_rem_nx;
         r_q        <= w_q_nx;
         r_dvsr     <= w_dvsr_nx;
         r_sign_q   <= w_sign_q_nx;
         r_sign_r   <= w_sign_r_nx;
         r_cnt      <= w_cnt_nx;
         r_hi       <= w_hi_nx;
         r_lo       <= w_lo_nx;
         r_busy     <= w_busy_nx;
         r_done     <= w_done_nx;
         r_div_zero <= w_div_zero_nx;
      end
   end

   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.div_zero = r_div_zero;
   assign bus.hi       = r_hi;
   assign bus.lo       = r_lo;
endmodule

// File: tb/tb_div_restoring.sv
// Directed self-checking bench for div_restoring.
module tb_div_restoring;
   import div_pkg::*;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   div_restoring_if #(.WIDTH(DIV_WIDTH)) bus ();

   div_restoring dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one division and follow it to done. k counts edges after acceptance.
   // If inj >= 0, a competing start with other operands is raised at step inj.
   task automatic run_div(input logic [31:0] dvd, input logic [31:0] dvs,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input int inj, input string tag);
      int k;
      int busy_cnt;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = dvd;
      bus.divisor  = dvs;
      @(negedge clk);
      bus.start = 1'b0;
      k         = 0;
      busy_cnt  = 0;
      while (!bus.done && k < 40) begin
         if (bus.busy) busy_cnt++;
         if (k == inj) begin
            bus.start    = 1'b1;
            bus.dividend = 32'd100;
            bus.divisor  = 32'd3;
         end else if (k == inj + 1) begin
            bus.start    = 1'b0;
            bus.dividend = 32'd55;
            bus.divisor  = 32'd0;
         end
         @(negedge clk);
         k++;
      end
      chk(32'(k),        32'd33,  {tag, " latency"});
      chk(32'(busy_cnt), 32'd33,  {tag, " busy cycles"});
      chk({31'd0, bus.busy},     32'd0, {tag, " busy at done"});
      chk({31'd0, bus.div_zero}, 32'd0, {tag, " div_zero at done"});
      chk(bus.lo, exp_lo, {tag, " lo"});
      chk(bus.hi, exp_hi, {tag, " hi"});
      @(negedge clk);
      chk({31'd0, bus.done}, 32'd0, {tag, " done width"});
   endtask

   initial begin
      int seen;
      n_tests      = 0;
      n_fail       = 0;
      reset        = 1'b0;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (2) @(negedge clk);

      // Reset state
      chk({31'd0, bus.busy},     32'd0, "rst busy");
      chk({31'd0, bus.done},     32'd0, "rst done");
      chk({31'd0, bus.div_zero}, 32'd0, "rst div_zero");
      chk(bus.hi, 32'd0, "rst hi");
      chk(bus.lo, 32'd0, "rst lo");
      reset = 1'b1;

      // Signed quotient/remainder cases
      run_div(32'd7,        32'd2,        32'd3,        32'd1,        -5, "7/2");
      run_div(32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, -5, "-7/2");
      run_div(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        -5, "min/-1");
      run_div(32'd0,        32'd5,        32'd0,        32'd0,        -5, "0/5");
      run_div(32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        -5, "7/-2");

      // Divide by zero keeps previous hi/lo (1, 0xFFFFFFFD)
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 32'd100;
      bus.divisor  = 32'd0;
      @(negedge clk);
      bus.start = 1'b0;
      chk({31'd0, bus.done},     32'd1, "dz done");
      chk({31'd0, bus.div_zero}, 32'd1, "dz div_zero");
      chk({31'd0, bus.busy},     32'd0, "dz busy");
      chk(bus.hi, 32'd1,         "dz hi kept");
      chk(bus.lo, 32'hFFFFFFFD,  "dz lo kept");
      @(negedge clk);
      chk({31'd0, bus.done},     32'd0, "dz done width");
      chk({31'd0, bus.div_zero}, 32'd0, "dz div_zero width");
      chk({31'd0, bus.busy},     32'd0, "dz busy after");

      // Competing start mid-run and later operand changes are ignored
      run_div(32'd7, 32'd2, 32'd3, 32'd1, 10, "7/2 ignore");

      // Reset mid-run aborts without a done pulse
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 32'd50;
      bus.divisor  = 32'd7;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (15) @(negedge clk);
      reset = 1'b0;
      #1;
      chk({31'd0, bus.busy}, 32'd0, "abort busy");
      chk({31'd0, bus.done}, 32'd0, "abort done");
      chk(bus.hi, 32'd0, "abort hi");
      chk(bus.lo, 32'd0, "abort lo");
      @(negedge clk);
      reset = 1'b1;
      seen  = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) seen++;
      end
      chk(32'(seen), 32'd0, "abort no done");

      run_div(32'd9, 32'd4, 32'd2, 32'd1, -5, "9/4");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
